add_pipe: RTL and testbench
===========================

Name: add_pipe

Overview:
- Parametrised, pipelined successor to the Hack 16-bit ripple adder. It adds or subtracts two WIDTH-bit operands with a carry-in.
- The carry chain is split into STAGES equal slices, with one register stage per slice.
- Valid/ready handshakes with backpressure on both sides.
- Result carries cout, zero, negative and signed-overflow flags. It feeds the ALU datapath and address-increment paths where a single-cycle 16-bit ripple chain limits timing.

Parameters:
- WIDTH, 16, operand/result width in bits; must be divisible by STAGES.
- STAGES, 2, number of pipeline slices/register stages (>=1); slice width SW = WIDTH/STAGES.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  1 = A - B (A + ~B + 1), cin ignored; 0 = A + B + cin.
- cin  in  1  carry-in for add mode.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB (sub mode: 1 = no borrow).
- zero  out  1  sum == 0.
- neg  out  1  sum[WIDTH-1].
- ovf  out  1  signed overflow.

Behaviour:
- Effective operand: b_eff = sub ? ~b : b. Effective carry-in: c0 = sub ? 1 : cin. Both are resolved at input acceptance.
- Slice k (0..STAGES-1) covers bits [k*SW +: SW].
  - Stage k adds slice k of a and b_eff, using the carry registered by stage k-1 (stage 0 uses c0).
  - Stage k registers its sum slice, carry-out and valid bit.
  - Unprocessed upper operand slices and already-computed lower sum slices travel alongside in stage registers (skew/deskew). Each result is delivered as one aligned beat.
- Latency: exactly STAGES cycles from accepted input to out_valid, absent backpressure. Throughput: one beat per cycle.
- Stall rule: the global enable is en = !out_valid || out_ready, and in_ready = en.
  - When en=0, all stage registers hold.
  - Bubbles inside the pipe are not collapsed.
  - Input is accepted only when in_valid && in_ready.
- Output hold: while out_valid && !out_ready, sum/cout/flags/out_valid stay stable.
- Flags are computed in the final stage and registered with sum, so they carry no extra latency:
  - zero: all WIDTH result bits are 0.
  - neg: result MSB.
  - ovf: (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
  - cout: carry out of the final slice.
- Reset (async, any time including mid-operation): all stage valid bits clear, so out_valid=0. sum=0, cout=0, zero=0, neg=0, ovf=0.
  - In-flight beats are discarded; no result for them appears after reset release.
  - in_ready=1 during and after reset.
- STAGES=1: one register stage, latency 1.
- STAGES=WIDTH: 1-bit slices.
- Simultaneous accept and output drain in the same cycle is legal and sustains full throughput.

Decomposition:
- Shared package/header holds default width constant HACK_WORD=16 and a compile-time check macro for WIDTH % STAGES == 0.
- One natural sub-module: add_slice. It is a combinational SW-bit ripple adder (a, b, cin -> sum, cout) built from the existing full_adder cell. add_pipe instantiates STAGES of these with a generate loop, and owns all registers and handshake logic.

Test Plan:
- WIDTH=16, STAGES=2: a=0x1234, b=0x0FFF, sub=0, cin=0 -> 2 cycles later sum=0x2233, cout=0, zero=0, neg=0, ovf=0.
- Cross-slice carry: a=0x00FF, b=0x0001, cin=0 -> sum=0x0100; a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, zero=1.
- Subtract: a=5, b=5, sub=1 -> sum=0x0000, zero=1, cout=1. Then a=3, b=5, sub=1 -> sum=0xFFFE, neg=1, cout=0.
- Overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, neg=1. a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
- Backpressure: stream 6 back-to-back beats with out_ready low for 3 cycles mid-stream -> in_ready drops while the pipe is full, outputs stay stable while stalled, all 6 results arrive in order with no loss or duplication.
- Reset mid-flight: 2 beats in the pipe, pulse rst_n low asynchronously between edges -> out_valid=0 and sum=0 immediately, no output beats after release. Repeat the arithmetic checks with STAGES=1, 4 and 16.

Source files
------------

// File: rtl/add_pipe_pkg.sv
// Shared constants and helpers for the pipelined Hack adder.
// Also defines the WIDTH/STAGES divisibility check used at elaboration.
`ifndef ADD_PIPE_PKG_SV
`define ADD_PIPE_PKG_SV

`define ADD_PIPE_CHECK_DIV(W, S) \
    if (((S) < 1) || (((W) % (S)) != 0)) begin : g_bad_div \
        $error("add_pipe: WIDTH must be a positive multiple of STAGES"); \
    end

package add_pipe_pkg;

    localparam int unsigned HACK_WORD = 16;

    function automatic logic ovf_flag(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

`endif

// File: rtl/add_pipe_slice.sv
// Combinational SW-bit ripple-carry slice built from full_adder cells.
// The carry chain is threaded through per-bit generate scopes.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module add_slice #(
    parameter int unsigned SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout
);
    for (genvar i = 0; i < SW; i++) begin : g_bit
        logic w_ci;
        logic w_co;
        if (i == 0) begin : g_lsb
            assign w_ci = cin;
        end else begin : g_chain
            assign w_ci = g_bit[i-1].w_co;
        end
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_ci),
            .sum  (sum[i]),
            .cout (w_co)
        );
    end

    assign cout = g_bit[SW-1].w_co;
endmodule

// File: rtl/add_pipe.sv
// Pipelined add/subtract: one SW-bit carry slice per register stage.
// Operands skew forward with the partial sum; one aligned beat leaves the last stage.
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = HACK_WORD,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);
    localparam int unsigned SW = WIDTH / STAGES;
    localparam int unsigned LS = STAGES - 1;

    `ADD_PIPE_CHECK_DIV(WIDTH, STAGES)

    logic             w_en;
    logic [WIDTH-1:0] w_a_in   [STAGES];
    logic [WIDTH-1:0] w_b_in   [STAGES];
    logic [WIDTH-1:0] w_sum_in [STAGES];
    logic             w_c_in   [STAGES];
    logic             w_v_in   [STAGES];
    logic [WIDTH-1:0] w_sum_nx [STAGES];
    logic             w_c_nx   [STAGES];

    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic             r_c   [STAGES];
    logic             r_v   [STAGES];
    logic             r_zero;
    logic             r_neg;
    logic             r_ovf;

    logic             w_zero;
    logic             w_neg;
    logic             w_ovf;

    // A full output register that is not being drained freezes the whole pipe.
    assign w_en     = !r_v[LS] || out_ready;
    assign in_ready = w_en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0]    w_slice_sum;
        logic [WIDTH-1:0] w_merged;

        if (k == 0) begin : g_head
            assign w_a_in[k]   = a;
            assign w_b_in[k]   = sub ? ~b : b;
            assign w_c_in[k]   = sub ? 1'b1 : cin;
            assign w_v_in[k]   = in_valid;
            assign w_sum_in[k] = {WIDTH{1'b0}};
        end else begin : g_body
            assign w_a_in[k]   = r_a[k-1];
            assign w_b_in[k]   = r_b[k-1];
            assign w_c_in[k]   = r_c[k-1];
            assign w_v_in[k]   = r_v[k-1];
            assign w_sum_in[k] = r_sum[k-1];
        end

        add_slice #(.SW(SW)) u_slice (
            .a    (w_a_in[k][k*SW +: SW]),
            .b    (w_b_in[k][k*SW +: SW]),
            .cin  (w_c_in[k]),
            .sum  (w_slice_sum),
            .cout (w_c_nx[k])
        );

        // Splice this stage's slice into the partial sum travelling with the beat.
        always_comb begin
            w_merged                = w_sum_in[k];
            w_merged[k*SW +: SW]    = w_slice_sum;
        end

        assign w_sum_nx[k] = w_merged;
    end

    // Result flags come from the completed sum so they register alongside it.
    always_comb begin
        w_zero = ~|w_sum_nx[LS];
        w_neg  = w_sum_nx[LS][WIDTH-1];
        w_ovf  = ovf_flag(w_a_in[LS][WIDTH-1], w_b_in[LS][WIDTH-1], w_sum_nx[LS][WIDTH-1]);
    end

    // Stage registers and output flags; all advance together on the global enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= {WIDTH{1'b0}};
                r_b[k]   <= {WIDTH{1'b0}};
                r_sum[k] <= {WIDTH{1'b0}};
                r_c[k]   <= 1'b0;
                r_v[k]   <= 1'b0;
            end
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= w_a_in[k];
                r_b[k]   <= w_b_in[k];
                r_sum[k] <= w_sum_nx[k];
                r_c[k]   <= w_c_nx[k];
                r_v[k]   <= w_v_in[k];
            end
            r_zero <= w_zero;
            r_neg  <= w_neg;
            r_ovf  <= w_ovf;
        end
    end

    assign out_valid = r_v[LS];
    assign sum       = r_sum[LS];
    assign cout      = r_c[LS];
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_add_pipe.sv
// Directed bench for add_pipe: four instances (STAGES 2,1,4,16) share the stimulus;
// instance 0 additionally sees backpressure and a mid-flight reset.
module tb_add_pipe;
    localparam int NDUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic        out_ready;

    logic        in_ready_d  [NDUT];
    logic        out_valid_d [NDUT];
    logic [15:0] sum_d       [NDUT];
    logic        cout_d      [NDUT];
    logic        zero_d      [NDUT];
    logic        neg_d       [NDUT];
    logic        ovf_d       [NDUT];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    add_pipe #(.WIDTH(16), .STAGES(2)) u_dut_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d[0]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_d[0]), .out_ready(out_ready),
        .sum(sum_d[0]), .cout(cout_d[0]), .zero(zero_d[0]), .neg(neg_d[0]), .ovf(ovf_d[0])
    );
    add_pipe #(.WIDTH(16), .STAGES(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d[1]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_d[1]), .out_ready(out_ready),
        .sum(sum_d[1]), .cout(cout_d[1]), .zero(zero_d[1]), .neg(neg_d[1]), .ovf(ovf_d[1])
    );
    add_pipe #(.WIDTH(16), .STAGES(4)) u_dut_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d[2]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_d[2]), .out_ready(out_ready),
        .sum(sum_d[2]), .cout(cout_d[2]), .zero(zero_d[2]), .neg(neg_d[2]), .ovf(ovf_d[2])
    );
    add_pipe #(.WIDTH(16), .STAGES(16)) u_dut_s16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d[3]),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid_d[3]), .out_ready(out_ready),
        .sum(sum_d[3]), .cout(cout_d[3]), .zero(zero_d[3]), .neg(neg_d[3]), .ovf(ovf_d[3])
    );

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            3:       return 16;
            default: return 0;
        endcase
    endfunction

    // {cout, zero, neg, ovf, sum}
    function automatic logic [19:0] res_of(input int d);
        return {cout_d[d], zero_d[d], neg_d[d], ovf_d[d], sum_d[d]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic run_vec(input string name, input logic [15:0] va, input logic [15:0] vb,
                           input logic vsub, input logic vcin, input logic [19:0] exp);
        bit got [NDUT];
        for (int d = 0; d < NDUT; d++) got[d] = 1'b0;
        @(negedge clk);
        a = va; b = vb; sub = vsub; cin = vcin; in_valid = 1'b1; out_ready = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) in_valid = 1'b0;
            for (int d = 0; d < NDUT; d++) begin
                if (out_valid_d[d] && !got[d]) begin
                    got[d] = 1'b1;
                    check_eq($sformatf("%s_s%0d_lat", name, lat_of(d)), 32'(n), 32'(lat_of(d)));
                    check_eq($sformatf("%s_s%0d_res", name, lat_of(d)), 32'(res_of(d)), 32'(exp));
                end
            end
        end
        for (int d = 0; d < NDUT; d++)
            check_eq($sformatf("%s_s%0d_seen", name, lat_of(d)), 32'(got[d]), 32'd1);
    endtask

    task automatic run_stream();
        int          sent = 0;
        int          rcvd = 0;
        int          stall_seen = 0;
        bit          prev_stall = 1'b0;
        logic [15:0] held_sum = 16'h0000;
        sub = 1'b0; cin = 1'b0; b = 16'h00F0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c <= 6);
            in_valid  = (sent < 6);
            a         = 16'(16'h0101 * (sent + 1));
            #1;
            if (prev_stall) begin
                check_eq("bp_hold_valid", 32'(out_valid_d[0]), 32'd1);
                check_eq("bp_hold_sum", 32'(sum_d[0]), 32'(held_sum));
            end
            prev_stall = out_valid_d[0] && !out_ready;
            held_sum   = sum_d[0];
            if (!in_ready_d[0]) stall_seen++;
            if (out_valid_d[0] && out_ready) begin
                rcvd++;
                check_eq($sformatf("bp_beat%0d", rcvd), 32'(sum_d[0]),
                         32'(16'(16'h0101 * rcvd + 16'h00F0)));
            end
            if (in_valid && in_ready_d[0]) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("bp_count", 32'(rcvd), 32'd6);
        check_eq("bp_inready_low", 32'(stall_seen != 0), 32'd1);
    endtask

    task automatic run_reset();
        int late_valid = 0;
        @(negedge clk);
        out_ready = 1'b1; sub = 1'b0; cin = 1'b0;
        in_valid = 1'b1; a = 16'h1111; b = 16'h1111;
        @(posedge clk);
        #1 a = 16'h2222;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check_eq("rst_pre_valid", 32'(out_valid_d[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check_eq($sformatf("rst_mid_valid_s%0d", lat_of(d)), 32'(out_valid_d[d]), 32'd0);
            check_eq($sformatf("rst_mid_res_s%0d", lat_of(d)), 32'(res_of(d)), 32'd0);
            check_eq($sformatf("rst_mid_rdy_s%0d", lat_of(d)), 32'(in_ready_d[d]), 32'd1);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < NDUT; d++) if (out_valid_d[d]) late_valid++;
        end
        check_eq("rst_no_late_beats", 32'(late_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; a = 16'h0000; b = 16'h0000;
        sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        for (int d = 0; d < NDUT; d++) begin
            check_eq($sformatf("reset_valid_s%0d", lat_of(d)), 32'(out_valid_d[d]), 32'd0);
            check_eq($sformatf("reset_res_s%0d", lat_of(d)), 32'(res_of(d)), 32'd0);
            check_eq($sformatf("reset_rdy_s%0d", lat_of(d)), 32'(in_ready_d[d]), 32'd1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_vec("add_basic",   16'h1234, 16'h0FFF, 1'b0, 1'b0, 20'h0_2233);
        run_vec("add_xslice",  16'h00FF, 16'h0001, 1'b0, 1'b0, 20'h0_0100);
        run_vec("add_wrap",    16'hFFFF, 16'h0000, 1'b0, 1'b1, 20'hC_0000);
        run_vec("sub_equal",   16'h0005, 16'h0005, 1'b1, 1'b0, 20'hC_0000);
        run_vec("sub_borrow",  16'h0003, 16'h0005, 1'b1, 1'b0, 20'h2_FFFE);
        run_vec("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 20'h3_8000);
        run_vec("sub_ovf",     16'h8000, 16'h0001, 1'b1, 1'b0, 20'h9_7FFF);
        run_vec("sub_cin_ign", 16'h0010, 16'h0001, 1'b1, 1'b1, 20'h8_000F);
        run_vec("add_cin",     16'h0001, 16'h0001, 1'b0, 1'b1, 20'h0_0003);
        run_vec("add_negovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 20'hD_0000);

        run_stream();
        repeat (20) @(negedge clk);
        run_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
